branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of direct-mapped entries; power of 2, minimum 2; IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter CNT_W, default 2: width of the per-entry saturating direction counter; minimum 1.
REQ-003 SHALL have parameter ADDR_W, default 32: PC and target width; TAG_W = ADDR_W-2-IDX_W.
REQ-004 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port lookup_en  input  1  lookup valid this cycle; used only for statistics.
REQ-007 SHALL have port lookup_pc  input  ADDR_W  PC being fetched.
REQ-008 SHALL have port pred_hit  output  1  valid entry with matching tag.
REQ-009 SHALL have port pred_taken  output  1  predict taken.
REQ-010 SHALL have port pred_target  output  ADDR_W  predicted target.
REQ-011 SHALL have port upd_en  input  1  resolved branch update strobe.
REQ-012 SHALL have port upd_pc  input  ADDR_W  PC of the resolved branch.
REQ-013 SHALL have port upd_taken  input  1  resolved direction.
REQ-014 SHALL have port upd_target  input  ADDR_W  resolved target.
REQ-015 SHALL have port flush  input  1  invalidate all entries.

Function
REQ-016 SHALL compute index = pc[IDX_W+1:2] and tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-017 SHALL give each entry valid (1b), tag (TAG_W), target (ADDR_W-2, word address), cnt (CNT_W).
REQ-018 SHALL produce lookup outputs combinationally from current state, zero latency.
REQ-019 SHALL drive pred_hit = entry.valid AND entry.tag == lookup tag.
REQ-020 SHALL drive pred_taken = pred_hit AND cnt[CNT_W-1].
REQ-021 SHALL drive pred_target = {entry.target, 2'b00} when pred_hit, else 0.
REQ-022 SHALL, on upd_en with hit (valid, tag match): increment cnt saturating at all-ones if upd_taken, else decrement saturating at 0; if upd_taken also overwrite target.
REQ-023 SHALL, on upd_en with miss and upd_taken=1: allocate/replace the entry: valid=1, new tag, target=upd_target[ADDR_W-1:2], cnt = weakly taken (1 << (CNT_W-1)).
REQ-024 SHALL, on upd_en with miss and upd_taken=0: leave the entry unchanged.
REQ-025 SHALL apply updates at the next rising edge; lookup and update to the same index in the same cycle return pre-update contents (no bypass).
REQ-026 SHALL, on flush: clear every valid bit at the next edge; tag, target and cnt retained.
REQ-027 SHALL, on flush and upd_en together: let flush win; the update is dropped.
REQ-028 SHALL, with CNT_W=1: treat cnt as last-direction; allocate with cnt=1.

Reset
REQ-029 SHALL, while RST=1 at a rising edge: clear valid, tag, target and cnt of all entries to 0; RST overrides flush and upd_en.
REQ-030 SHALL, after reset: pred_hit=0, pred_taken=0, pred_target=0 for every lookup_pc.
REQ-031 SHALL, when RST is asserted mid-sequence: abandon any pending update; no partial entry write.

Configuration
REQ-032 SHALL, with macro BTB_STATS_EN defined: add outputs stat_lookups[31:0] and stat_hits[31:0].
REQ-033 SHALL, with BTB_STATS_EN defined: increment stat_lookups on each edge with lookup_en=1, and stat_hits when lookup_en AND pred_hit.
REQ-034 SHALL make both stat counters saturate at 0xFFFFFFFF, clear on RST, and be unaffected by flush.
REQ-035 SHALL, without BTB_STATS_EN: have no stat ports and no counter logic; all other behaviour identical.

Verification (ENTRIES=16, CNT_W=2, ADDR_W=32)
REQ-036 SHALL cover: RST 1 cycle, lookup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0.
REQ-037 SHALL cover: upd_en, upd_pc=0x00000104, taken, target=0x00000200; next cycle lookup 0x00000104 -> hit=1, taken=1, target=0x00000200; lookup 0x00000144 (same index, tag differs) -> hit=0.
REQ-038 SHALL cover: on that entry, 2 not-taken updates -> cnt 10->01->00, pred_taken=0, hit=1; third not-taken keeps cnt=00; 3 taken updates -> cnt 11, a 4th stays 11.
REQ-039 SHALL cover: lookup and upd_en to 0x00000104 in the same cycle -> old prediction that cycle, new one the next; not-taken update to an unallocated PC -> hit stays 0.
REQ-040 SHALL cover: flush with upd_en=1 to 0x00000300 -> all hits 0 next cycle, 0x00000300 not allocated.
REQ-041 SHALL cover, with BTB_STATS_EN: 5 lookup_en cycles with 2 hits -> stat_lookups=5, stat_hits=2; preload 0xFFFFFFFF (force) and look up again -> stat_lookups stays 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters; define BTB_STATS_EN to add lookup/hit statistics counters
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);
  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-3:0]   target_q [ENTRIES];
  logic [CNT_W-1:0]    cnt_q    [ENTRIES];
  logic [IDX_W-1:0]    l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                u_hit;
  logic [CNT_W-1:0]    u_cnt;
  logic                unused_ok;
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_ok = ^{lookup_en, lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};
  // zero-latency lookup from current state, no bypass of same-cycle updates
  always_comb begin
    pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && cnt_q[l_idx][CNT_W-1];
    pred_target = pred_hit ? {target_q[l_idx], 2'b00} : '0;
  end
  // update-side hit detection and next saturating counter value
  always_comb begin
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_cnt = upd_taken ? ((cnt_q[u_idx] == CNT_MAX) ? CNT_MAX : cnt_q[u_idx] + CNT_W'(1))
                      : ((cnt_q[u_idx] == '0) ? '0 : cnt_q[u_idx] - CNT_W'(1));
  end
  // entry state: reset clears all, flush clears valid only and beats updates
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_en) begin
      if (u_hit) begin
        cnt_q[u_idx] <= u_cnt;
        if (upd_taken) target_q[u_idx] <= upd_target[ADDR_W-1:2];
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target[ADDR_W-1:2];
        cnt_q[u_idx]    <= CNT_WEAK;
      end
    end
  end
`ifdef BTB_STATS_EN
  // saturating statistics, immune to flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
    end else if (lookup_en) begin
      stat_lookups <= (stat_lookups == '1) ? stat_lookups : stat_lookups + 32'd1;
      if (pred_hit) stat_hits <= (stat_hits == '1) ? stat_hits : stat_hits + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush = 1'b0;
  int          n_checks = 0;
  int          n_fails  = 0;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits;
`endif
  branch_target_buffer #(.ENTRIES(16), .CNT_W(2), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({tag, "_target"}, pred_target, tgt);
  endtask
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    cyc();
    upd_en = 1'b0;
  endtask
  initial begin
    cyc();
    RST = 1'b0;
    look("reset", 32'h40, 0, 0, 0);
    look("reset_b", 32'h104, 0, 0, 0);
    upd(32'h104, 1, 32'h200);
    look("alloc", 32'h104, 1, 1, 32'h200);
    look("lowbits", 32'h107, 1, 1, 32'h200);
    look("tagdiff", 32'h144, 0, 0, 0);
    upd(32'h104, 0, 32'h0);
    look("nt1", 32'h104, 1, 0, 32'h200);
    upd(32'h104, 0, 32'h0);
    look("nt2", 32'h104, 1, 0, 32'h200);
    upd(32'h104, 0, 32'h0);
    upd(32'h104, 1, 32'h200);
    look("sat0_t1", 32'h104, 1, 0, 32'h200);
    upd(32'h104, 1, 32'h200);
    look("t2", 32'h104, 1, 1, 32'h200);
    upd(32'h104, 1, 32'h200);
    upd(32'h104, 1, 32'h300);
    look("t4_newtgt", 32'h104, 1, 1, 32'h300);
    upd(32'h104, 0, 32'h0);
    look("sat3_nt", 32'h104, 1, 1, 32'h300);
    lookup_pc = 32'h104;
    upd_en = 1'b1; upd_pc = 32'h104; upd_taken = 1'b0; upd_target = '0;
    #1;
    check("same_cycle_old", {31'd0, pred_taken}, 32'd1);
    cyc();
    upd_en = 1'b0;
    look("same_cycle_new", 32'h104, 1, 0, 32'h300);
    upd(32'h208, 0, 32'h500);
    look("nt_noalloc", 32'h208, 0, 0, 0);
    upd(32'h208, 1, 32'h600);
    look("alloc2", 32'h208, 1, 1, 32'h600);
    flush = 1'b1;
    upd(32'h300, 1, 32'h700);
    flush = 1'b0;
    look("flush_a", 32'h104, 0, 0, 0);
    look("flush_b", 32'h208, 0, 0, 0);
    look("flush_drop", 32'h300, 0, 0, 0);
    upd(32'h104, 1, 32'h400);
    look("realloc", 32'h104, 1, 1, 32'h400);
    RST = 1'b1;
    upd(32'h208, 1, 32'h800);
    RST = 1'b0;
    look("rst_mid_a", 32'h104, 0, 0, 0);
    look("rst_mid_b", 32'h208, 0, 0, 0);
`ifdef BTB_STATS_EN
    check("stat_rst", stat_lookups, 32'd0);
    upd(32'h104, 1, 32'h200);
    lookup_en = 1'b1;
    lookup_pc = 32'h104; cyc();
    lookup_pc = 32'h40;  cyc();
    lookup_pc = 32'h104; cyc();
    lookup_pc = 32'h44;  cyc();
    lookup_pc = 32'h48;  cyc();
    lookup_en = 1'b0;
    check("stat_lookups", stat_lookups, 32'd5);
    check("stat_hits", stat_hits, 32'd2);
    flush = 1'b1; cyc(); flush = 1'b0;
    check("stat_flush", stat_lookups, 32'd5);
    force dut.stat_lookups = 32'hFFFF_FFFF;
    #1;
    release dut.stat_lookups;
    lookup_en = 1'b1; cyc(); lookup_en = 1'b0;
    check("stat_sat", stat_lookups, 32'hFFFF_FFFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
